// File: rtl/reg_bank_dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// reg_bank_dump_ctrl_if
// Groups the two buses owned by the register-bank dump controller:
//   - bank read port A : read_reg (address out), read_data (word back, one
//                        cycle after the address is presented)
//   - byte stream      : tx_data / tx_valid (towards the debug UART TX),
//                        tx_ready (sink accepts the byte this cycle)
// Modports:
//   master : the dump controller (drives address and stream)
//   slave  : the bank / stream sink side
// -----------------------------------------------------------------------------
interface reg_bank_dump_ctrl_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = 8
);

  logic [NB_ADDR-1:0] read_reg;
  logic [NB_DATA-1:0] read_data;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output read_reg,
    input  read_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  read_reg,
    output read_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/reg_bank_dump_ctrl.sv
// -----------------------------------------------------------------------------
// reg_bank_dump_ctrl
// Debug-side controller that borrows read port A of the register bank while
// the pipeline is halted, reads every register 0..BANK_DEPTH-1 and serializes
// each word MSB-byte-first onto a valid/ready byte stream.
// While idle, port A is handed straight through to the pipeline's decode
// address so the bank behaves as if this block were not there.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          synchronous, active-high reset
//   i_start          dump request, looked at only while idle
//   i_halted         pipeline halted; a dump starts/continues only while high
//   i_pipe_read_reg  pipeline read-A address (passed through while idle)
//   bus (master)     read_reg / read_data to the bank, tx_data / tx_valid /
//                    tx_ready byte stream
//   o_busy           high in every state except idle
//   o_done           one-cycle pulse after a complete dump
// -----------------------------------------------------------------------------
module reg_bank_dump_ctrl #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int BANK_DEPTH = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_halted,
  input  logic [NB_ADDR-1:0]     i_pipe_read_reg,
  reg_bank_dump_ctrl_if.master   bus,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int NUM_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(NUM_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_IDX  = NB_ADDR'(BANK_DEPTH - 1);
  localparam logic [NB_CNT-1:0]  CNT_ONE   = NB_CNT'(1);
  localparam logic [NB_ADDR-1:0] IDX_ONE   = NB_ADDR'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [NB_ADDR-1:0]   idx_r;
  logic [NB_CNT-1:0]    byte_cnt_r;
  logic [NB_DATA-1:0]   shift_r;
  logic                 tx_valid_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 accept_s;
  logic                 last_byte_s;
  logic                 last_word_s;

  // Next-state logic; a word boundary is the only place a dump may end early.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    last_byte_s  = (byte_cnt_r == LAST_BYTE);
    last_word_s  = (idx_r == LAST_IDX);
    case (state_r)
      ST_IDLE: begin
        if (i_start && i_halted) begin
          next_state_s = ST_ADDR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        next_state_s = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        next_state_s = ST_SEND;
      end
      ST_SEND: begin
        accept_s = bus.tx_ready;
        if (bus.tx_ready && last_byte_s) begin
          if (last_word_s) begin
            next_state_s = ST_DONE;
          end else if (i_halted) begin
            next_state_s = ST_ADDR;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Port-A address mux: pipeline address passes through combinationally in idle.
  always_comb begin
    bus.read_reg = idx_r;
    if (state_r == ST_IDLE) begin
      bus.read_reg = i_pipe_read_reg;
    end else begin
      bus.read_reg = idx_r;
    end
  end

  // State register plus status flags registered from the upcoming state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      tx_valid_r <= (next_state_s == ST_SEND);
      busy_r     <= (next_state_s != ST_IDLE);
      done_r     <= (next_state_s == ST_DONE);
    end
  end

  // Datapath: register index, byte counter and output shift register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      idx_r      <= {NB_ADDR{1'b0}};
      byte_cnt_r <= {NB_CNT{1'b0}};
      shift_r    <= {NB_DATA{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (next_state_s == ST_ADDR) begin
            idx_r <= {NB_ADDR{1'b0}};
          end
        end
        ST_CAPTURE: begin
          // Bank data is valid here: the address went out in ADDR.
          shift_r    <= bus.read_data;
          byte_cnt_r <= {NB_CNT{1'b0}};
        end
        ST_SEND: begin
          if (accept_s) begin
            if (!last_byte_s) begin
              shift_r    <= shift_r << NB_BYTE;
              byte_cnt_r <= byte_cnt_r + CNT_ONE;
            end else if (next_state_s == ST_ADDR) begin
              // idx stays at LAST_IDX on the final word, so it never wraps.
              idx_r <= idx_r + IDX_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The top byte of the shift register is the byte on offer; it only moves on accept.
  assign bus.tx_data  = shift_r[NB_DATA-1 -: NB_BYTE];
  assign bus.tx_valid = tx_valid_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;

endmodule

// File: tb/tb_reg_bank_dump_ctrl.sv
module tb_reg_bank_dump_ctrl;

  localparam int NB_DATA    = 32;
  localparam int NB_ADDR    = 5;
  localparam int BANK_DEPTH = 32;
  localparam int NB_BYTE    = 8;
  localparam int PAT_LEN    = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               start;
  logic               halted;
  logic [NB_ADDR-1:0] pipe_reg;
  logic               busy;
  logic               done;

  reg_bank_dump_ctrl_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) bus ();

  reg_bank_dump_ctrl #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .BANK_DEPTH(BANK_DEPTH), .NB_BYTE(NB_BYTE)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_start(start),
    .i_halted(halted),
    .i_pipe_read_reg(pipe_reg),
    .bus(bus),
    .o_busy(busy),
    .o_done(done)
  );

  // Register bank stand-in: synchronous read, data one cycle after the address.
  logic [NB_DATA-1:0] bank [BANK_DEPTH];
  always @(posedge clk) bus.read_data <= bank[bus.read_reg];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_edge = 0;
  bit ready_pat [PAT_LEN];

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: per-cycle pattern indexed by cycle number relative to start.
  initial begin
    int r;
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      r = cyc - start_edge + 1;
      bus.tx_ready = (r >= 1 && r < PAT_LEN) ? ready_pat[r] : 1'b1;
    end
  end

  // Monitor: records accepted bytes, done pulses and stall stability.
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         done_q[$];
  int         unstable_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) begin
      got_q.push_back(bus.tx_data);
      got_cyc_q.push_back(cyc - start_edge + 1);
    end
    if (done) done_q.push_back(cyc - start_edge + 1);
    if (prev_stall && !rst && (!bus.tx_valid || bus.tx_data !== prev_data)) unstable_cnt++;
    prev_stall = bus.tx_valid && !bus.tx_ready && !rst;
    prev_data  = bus.tx_data;
  end

  // Reference model: byte order and accept cycle of every byte, from the dump rules.
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  int         exp_done;

  function automatic void predict(input int n_words, input bit with_done);
    int t;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_done = -1;
    t = 3;
    for (int w = 0; w < n_words; w++) begin
      for (int b = 0; b < 4; b++) begin
        while (t < PAT_LEN - 1 && !ready_pat[t]) t++;
        exp_q.push_back(8'((bank[w] >> (8 * (3 - b))) & 32'h0000_00FF));
        exp_cyc_q.push_back(t);
        t++;
      end
      if (w == n_words - 1) begin
        if (with_done) exp_done = t;
      end else begin
        t += 2;
      end
    end
  endfunction

  task automatic set_ready(input int mode);
    for (int i = 0; i < PAT_LEN; i++) begin
      case (mode)
        0:       ready_pat[i] = 1'b1;
        1:       ready_pat[i] = (i % 2 == 1);
        default: ready_pat[i] = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic load_directed();
    for (int i = 0; i < BANK_DEPTH; i++) bank[i] = 32'd0;
    bank[1]  = 32'd555;
    bank[10] = 32'd99;
    bank[31] = 32'd111;
  endtask

  task automatic load_random();
    for (int i = 0; i < BANK_DEPTH; i++) bank[i] = $urandom;
    bank[0] = 32'd0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc_q.delete();
    done_q.delete();
    unstable_cnt = 0;
  endtask

  // Pulse start for one cycle; returns in cycle 1 (the ADDR cycle).
  task automatic start_dump();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_edge = cyc + 1;
    clear_mon();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run_cycles(3);
    @(negedge clk);
    checks++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b data=%h, need 0 0 0 00",
               bus.tx_valid, busy, done, bus.tx_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pipe_reg = 5'd9;
    @(negedge clk);
    checks++;
    if (bus.read_reg !== 5'd9) begin
      errors++;
      $display("FAIL reset_idle_mux: read_reg=%0d need 9", bus.read_reg);
    end
    run_cycles(1);
  endtask

  task automatic test_full_dump();
    int r;
    bit exp_busy;
    load_directed();
    set_ready(0);
    predict(32, 1'b1);
    start_dump();
    for (int i = 0; i < 196; i++) begin
      @(negedge clk);
      r = cyc - start_edge + 1;
      exp_busy = (r >= 1 && r <= 193);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL full_busy: cycle %0d busy=%b need %b", r, busy, exp_busy);
      end
    end
    run_cycles(1);
    checks++;
    if (got_q.size() != 128) begin
      errors++;
      $display("FAIL full_count: got %0d bytes need 128", got_q.size());
    end else begin
      for (int i = 0; i < 128; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i]) begin
          errors++;
          $display("FAIL full_byte[%0d]: %h@%0d need %h@%0d", i, got_q[i], got_cyc_q[i],
                   exp_q[i], exp_cyc_q[i]);
        end
      end
      checks++;
      if ({got_q[4], got_q[5], got_q[6], got_q[7]} !== 32'h0000_022B ||
          {got_q[40], got_q[41], got_q[42], got_q[43]} !== 32'h0000_0063 ||
          {got_q[124], got_q[125], got_q[126], got_q[127]} !== 32'h0000_006F) begin
        errors++;
        $display("FAIL full_known_words: r1=%h%h%h%h r10=%h%h%h%h r31=%h%h%h%h need 0000022B 00000063 0000006F",
                 got_q[4], got_q[5], got_q[6], got_q[7], got_q[40], got_q[41], got_q[42], got_q[43],
                 got_q[124], got_q[125], got_q[126], got_q[127]);
      end
      checks++;
      if (got_cyc_q[0] != 3 || got_cyc_q[127] != 192) begin
        errors++;
        $display("FAIL full_first_last_cycle: %0d %0d need 3 192", got_cyc_q[0], got_cyc_q[127]);
      end
    end
    checks++;
    if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != 193)) begin
      errors++;
      $display("FAIL full_done: pulses=%0d first=%0d need 1 at 193", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1);
    end
  endtask

  task automatic test_stall_dump(input int mode);
    set_ready(mode);
    predict(32, 1'b1);
    start_dump();
    run_cycles(exp_done + 4);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall%0d_count: got %0d bytes need %0d", mode, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i]) begin
          errors++;
          $display("FAIL stall%0d_byte[%0d]: %h@%0d need %h@%0d", mode, i, got_q[i], got_cyc_q[i],
                   exp_q[i], exp_cyc_q[i]);
        end
      end
    end
    checks++;
    if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != exp_done)) begin
      errors++;
      $display("FAIL stall%0d_done: pulses=%0d first=%0d need 1 at %0d", mode, done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, exp_done);
    end
    checks++;
    if (unstable_cnt != 0) begin
      errors++;
      $display("FAIL stall%0d_hold: %0d stalled cycles changed data/valid, need 0", mode, unstable_cnt);
    end
  endtask

  task automatic test_no_halt();
    logic [NB_ADDR-1:0] vals [5];
    vals = '{5'd3, 5'd7, 5'd31, 5'd0, 5'd18};
    halted = 1'b0;
    start = 1'b1;
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      pipe_reg = vals[i];
      @(negedge clk);
      checks++;
      if (bus.read_reg !== vals[i] || busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL nohalt[%0d]: read_reg=%0d busy=%b valid=%b need %0d 0 0", i,
                 bus.read_reg, busy, bus.tx_valid, vals[i]);
      end
    end
    run_cycles(1);
    start = 1'b0;
    halted = 1'b1;
    run_cycles(2);
  endtask

  task automatic test_abort();
    load_random();
    set_ready(0);
    predict(6, 1'b0);
    start_dump();
    run_cycles(33);
    halted = 1'b0;
    run_cycles(8);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done_pulses=%0d need 0 0", busy, done_q.size());
    end
    checks++;
    if (got_q.size() != 24) begin
      errors++;
      $display("FAIL abort_count: got %0d bytes need 24", got_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i]) begin
          errors++;
          $display("FAIL abort_byte[%0d]: %h@%0d need %h@%0d", i, got_q[i], got_cyc_q[i],
                   exp_q[i], exp_cyc_q[i]);
        end
      end
    end
    halted = 1'b1;
    run_cycles(1);
    test_stall_dump(0);
  endtask

  task automatic test_reset_mid();
    load_random();
    set_ready(0);
    start_dump();
    run_cycles(75);
    rst = 1'b1;
    run_cycles(1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: valid=%b busy=%b done=%b need 0 0 0", bus.tx_valid, busy, done);
    end
    checks++;
    if (got_q.size() != 50) begin
      errors++;
      $display("FAIL rstmid_count: got %0d bytes before reset need 50", got_q.size());
    end
    run_cycles(10);
    checks++;
    if (done_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: done_pulses=%0d busy=%b need 0 0", done_q.size(), busy);
    end
    test_stall_dump(2);
  endtask

  task automatic test_back_to_back();
    load_random();
    set_ready(0);
    predict(32, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_edge = cyc + 1;
    clear_mon();
    run_cycles(300);
    start = 1'b0;
    run_cycles(120);
    checks++;
    if (done_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d done pulses need 2", done_q.size());
    end else begin
      checks++;
      if (done_q[0] != 193 || done_q[1] - done_q[0] != 194) begin
        errors++;
        $display("FAIL b2b_spacing: done at %0d,%0d need 193 and +194", done_q[0], done_q[1]);
      end
    end
    checks++;
    if (got_q.size() != 256) begin
      errors++;
      $display("FAIL b2b_count: got %0d bytes need 256", got_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i % 128]) begin
          errors++;
          $display("FAIL b2b_byte[%0d]: %h need %h", i, got_q[i], exp_q[i % 128]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    halted = 1'b1;
    pipe_reg = 5'd0;
    for (int i = 0; i < BANK_DEPTH; i++) bank[i] = 32'd0;
    for (int i = 0; i < PAT_LEN; i++) ready_pat[i] = 1'b1;
    test_reset();
    test_full_dump();
    test_stall_dump(1);
    load_random();
    test_stall_dump(2);
    test_no_halt();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_dump_ctrl.md
Name: reg_bank_dump_ctrl

Overview:
- Debug-side controller that owns read port A of bank_register while the pipeline is halted.
- On a start request it walks every register from 0 to BANK_DEPTH-1 and reads each word through the shared port.
- Each word is serialized MSB-byte-first onto a byte stream with a valid/ready handshake, towards the debug UART TX.
- When idle, port A is transparently driven by the pipeline's decode-stage address.

Parameters:
NB_DATA, 32, register width in bits; must be a multiple of NB_BYTE
NB_ADDR, 5, register address width
BANK_DEPTH, 32, number of registers dumped (indices 0..BANK_DEPTH-1)
NB_BYTE, 8, output stream width

Ports:
i_clock  in  1  system clock; all state updates on the rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  dump request, sampled in IDLE only
i_halted  in  1  pipeline halted; dump may start and continue only while high
i_pipe_read_reg  in  NB_ADDR  pipeline read-A address
o_read_reg  out  NB_ADDR  to bank i_read_reg_a
i_read_data  in  NB_DATA  from bank o_data_a
o_tx_data  out  NB_BYTE  stream byte
o_tx_valid  out  1  stream byte valid
i_tx_ready  in  1  sink accepts the byte this cycle
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when a full dump has completed

Behaviour:
- Clock and reset: one clock (i_clock); reset is synchronous and active-high (i_reset).
- Reset: state=IDLE, idx=0, byte_cnt=0, shift register=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0.
- Reset mid-dump: everything returns to IDLE on the next edge, with no o_done pulse.
- Port-A mux: o_read_reg = i_pipe_read_reg in IDLE (combinational); o_read_reg = idx in all other states.
- Bank read data is sampled one cycle after the address is presented.

FSM states and transitions:
- IDLE: if i_start and i_halted, then idx<=0 and go to ADDR. i_start is ignored when i_halted=0. i_start is ignored outside IDLE (no queuing).
- ADDR: one cycle, drives idx on o_read_reg; go to CAPTURE.
- CAPTURE: shift<=i_read_data, byte_cnt<=0; go to SEND.
- SEND:
  - o_tx_valid=1 and o_tx_data=shift[NB_DATA-1 -: NB_BYTE].
  - o_tx_data is held stable while i_tx_ready=0.
  - On i_tx_ready=1 and byte_cnt<NB_DATA/NB_BYTE-1: shift<<=NB_BYTE, byte_cnt++.
  - On i_tx_ready=1 and last byte with idx==BANK_DEPTH-1: go to DONE.
  - On i_tx_ready=1 and last byte otherwise: if i_halted=1, idx++ and go to ADDR; if i_halted=0, abort to IDLE with no o_done.
  - Abort therefore happens only at a word boundary; a word, once started, is always fully delivered.
- DONE: o_done=1 for one cycle; go to IDLE.

Timing and boundaries:
- o_tx_valid never drops without an accept, except on reset.
- Latency with i_tx_ready held at 1 and i_start sampled at edge 0:
  - ADDR in cycle 1, first valid byte in cycle 3.
  - 6 cycles per word.
  - Last byte in cycle 192, o_done in cycle 193.
  - Total stream is 128 bytes.
- Wrap-around: idx never exceeds BANK_DEPTH-1; it is reset to 0 at each new start.
- i_start held high through DONE: the controller returns to IDLE, then immediately restarts on the next edge if i_halted=1.
- Register 0 is dumped like any other index; it reads as 0 from the bank.

Test Plan:
- Bank preloaded with r1=555, r10=99, r31=111 and all others 0; halted=1, 1-cycle start pulse, ready=1 -> 128 bytes. Bytes 4..7 = 00 00 02 2B, bytes 40..43 = 00 00 00 63, bytes 124..127 = 00 00 00 6F. o_done pulses in cycle 193; o_busy is high in cycles 1..193.
- Same dump with ready toggling 1,0,1,0 -> identical 128-byte sequence. o_tx_data is stable on every valid&!ready cycle. o_done is delayed by the number of stall cycles.
- start=1 with halted=0 -> remains in IDLE, o_busy=0. o_read_reg tracks i_pipe_read_reg, e.g. values 3, 7, 31 each appear on the same cycle they are applied.
- halted drops during the 2nd byte of word 5 -> word 5 completes (4 bytes, 24 bytes total), then IDLE with o_done=0. A subsequent start restarts from word 0.
- reset asserted during SEND of word 12 -> next cycle o_tx_valid=0, o_busy=0, o_done=0. A new start produces a full dump from r0.
- start held high for 300 cycles with halted=1 -> two complete dumps back-to-back, with o_done pulses separated by 194 cycles.
